// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns / InvMixColumns with valid/ready handshake.
// Processes COLS_PER_CYCLE columns per clock; last_round passes the state through unmixed.
module mix_columns_seq #(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic         inv,
   input  logic         last_round,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out
);

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
         $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   // STEP wraps to 0 for four columns per cycle; LAST_BASE is the counter value of the final chunk.
   localparam logic [1:0] STEP      = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_BASE = 2'(4 - COLS_PER_CYCLE);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           st;
   logic [0:3][31:0] data_q;
   logic [0:3][31:0] data_nxt;
   logic             inv_q;
   logic             last_q;
   logic [1:0]       cnt;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inverse);
      logic [0:3][7:0] a;
      logic [0:3][7:0] b;
      logic [0:3][7:0] x2;
      logic [0:3][7:0] x4;
      logic [0:3][7:0] x8;
      logic [1:0]      i0;
      logic [1:0]      i1;
      logic [1:0]      i2;
      logic [1:0]      i3;
      a = col;
      for (int unsigned r = 0; r < 4; r++) begin
         x2[2'(r)] = xtime(a[2'(r)]);
         x4[2'(r)] = xtime(x2[2'(r)]);
         x8[2'(r)] = xtime(x4[2'(r)]);
      end
      for (int unsigned r = 0; r < 4; r++) begin
         i0 = 2'(r);
         i1 = i0 + 2'd1;
         i2 = i0 + 2'd2;
         i3 = i0 + 2'd3;
         // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
         if (inverse)
            b[i0] = (x8[i0] ^ x4[i0] ^ x2[i0]) ^ (x8[i1] ^ x2[i1] ^ a[i1]) ^
                    (x8[i2] ^ x4[i2] ^ a[i2]) ^ (x8[i3] ^ a[i3]);
         else
            b[i0] = x2[i0] ^ (x2[i1] ^ a[i1]) ^ a[i2] ^ a[i3];
      end
      return b;
   endfunction

   always_comb begin
      data_nxt = data_q;
      for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
         if (!last_q)
            data_nxt[cnt + 2'(k)] = mix_col(data_q[cnt + 2'(k)], inv_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st        <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         state_out <= '0;
         cnt       <= '0;
         data_q    <= '0;
         inv_q     <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               if (in_valid && in_ready) begin
                  data_q   <= state_in;
                  inv_q    <= inv;
                  last_q   <= last_round;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  st       <= BUSY;
               end
            end
            BUSY: begin
               data_q <= data_nxt;
               cnt    <= cnt + STEP;
               if (cnt == LAST_BASE) begin
                  state_out <= data_nxt;
                  out_valid <= 1'b1;
                  st        <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  st        <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle)
// exercised in turn against known AES MixColumns vectors through an expected-value queue.
module tb_mix_columns_seq;

   localparam logic [127:0] V_PLAIN   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] V_MIX     = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] V_FIX_IN  = 128'h01010101c6c6c6c6d4d4d4d52d26314c;
   localparam logic [127:0] V_FIX_OUT = 128'h01010101c6c6c6c6d5d5d7d64d7ebdf8;
   localparam logic [127:0] V_COL_A   = {32'hdb135345, 96'h0};
   localparam logic [127:0] V_COL_B   = {32'h8e4da1bc, 96'h0};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [2:0]   in_valid = '0;
   logic [2:0]   out_ready = '0;
   logic [127:0] state_in = '0;
   logic         inv = 1'b0;
   logic         last_round = 1'b0;
   logic         ir0, ir1, ir2, ov0, ov1, ov2;
   logic [127:0] so0, so1, so2;

   int n_vec = 0;
   int n_err = 0;
   logic [127:0] exp_q[$];

   always #5 clk = ~clk;

   mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir0), .state_in(state_in),
      .inv(inv), .last_round(last_round), .out_valid(ov0), .out_ready(out_ready[0]), .state_out(so0));
   mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir1), .state_in(state_in),
      .inv(inv), .last_round(last_round), .out_valid(ov1), .out_ready(out_ready[1]), .state_out(so1));
   mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(ir2), .state_in(state_in),
      .inv(inv), .last_round(last_round), .out_valid(ov2), .out_ready(out_ready[2]), .state_out(so2));

   function automatic logic ir(input int sel);
      return (sel == 0) ? ir0 : (sel == 1) ? ir1 : ir2;
   endfunction
   function automatic logic ov(input int sel);
      return (sel == 0) ? ov0 : (sel == 1) ? ov1 : ov2;
   endfunction
   function automatic logic [127:0] so(input int sel);
      return (sel == 0) ? so0 : (sel == 1) ? so1 : so2;
   endfunction
   function automatic int cpc_of(input int sel);
      return (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
   endfunction
   function automatic int n_of(input int sel);
      return 4 / cpc_of(sel);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one transaction for one edge, then scramble the sideband inputs to show they are ignored.
   task automatic send(input int sel, input logic [127:0] d, input logic iv, input logic lr,
                       input logic [127:0] expv);
      state_in = d; inv = iv; last_round = lr; in_valid[sel] = 1'b1;
      tick();
      in_valid[sel] = 1'b0; state_in = ~d; inv = ~iv; last_round = ~lr;
      exp_q.push_back(expv);
   endtask

   task automatic wait_out(input int sel, output int lat);
      lat = 0;
      while (ov(sel) !== 1'b1 && lat < 12) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      for (int s = 0; s < 3; s++) begin
         n_vec++; if (ir(s) !== 1'b1) begin n_err++; $display("FAIL reset_in_ready cpc=%0d got %b want 1", cpc_of(s), ir(s)); end
         n_vec++; if (ov(s) !== 1'b0) begin n_err++; $display("FAIL reset_out_valid cpc=%0d got %b want 0", cpc_of(s), ov(s)); end
         n_vec++; if (so(s) !== 128'h0) begin n_err++; $display("FAIL reset_state_out cpc=%0d got %h want 0", cpc_of(s), so(s)); end
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fips(input int sel);
      int lat;
      logic [127:0] e;
      out_ready[sel] = 1'b1;
      n_vec++; if (ir(sel) !== 1'b1) begin n_err++; $display("FAIL fips_ready_idle cpc=%0d got %b want 1", cpc_of(sel), ir(sel)); end
      send(sel, V_PLAIN, 1'b0, 1'b0, V_MIX);
      n_vec++; if (ir(sel) !== 1'b0) begin n_err++; $display("FAIL fips_ready_busy cpc=%0d got %b want 0", cpc_of(sel), ir(sel)); end
      wait_out(sel, lat);
      e = exp_q.pop_front();
      n_vec++; if (lat !== n_of(sel)) begin n_err++; $display("FAIL fips_latency cpc=%0d got %0d want %0d", cpc_of(sel), lat, n_of(sel)); end
      n_vec++; if (so(sel) !== e) begin n_err++; $display("FAIL fips_data cpc=%0d got %h want %h", cpc_of(sel), so(sel), e); end
      tick();
      n_vec++; if (ov(sel) !== 1'b0) begin n_err++; $display("FAIL fips_valid_pulse cpc=%0d got %b want 0", cpc_of(sel), ov(sel)); end
      n_vec++; if (ir(sel) !== 1'b1) begin n_err++; $display("FAIL fips_ready_back cpc=%0d got %b want 1", cpc_of(sel), ir(sel)); end
      out_ready[sel] = 1'b0;
   endtask

   task automatic test_inverse(input int sel);
      logic [127:0] din [3];
      logic [127:0] dexp [3];
      logic         dinv [3];
      int lat;
      logic [127:0] e;
      din  = '{V_MIX, V_COL_A, V_COL_B};
      dexp = '{V_PLAIN, V_COL_B, V_COL_A};
      dinv = '{1'b1, 1'b0, 1'b1};
      out_ready[sel] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(sel, din[i], dinv[i], 1'b0, dexp[i]);
         wait_out(sel, lat);
         e = exp_q.pop_front();
         n_vec++; if (lat !== n_of(sel)) begin n_err++; $display("FAIL inv_latency cpc=%0d case=%0d got %0d want %0d", cpc_of(sel), i, lat, n_of(sel)); end
         n_vec++; if (so(sel) !== e) begin n_err++; $display("FAIL inv_data cpc=%0d case=%0d got %h want %h", cpc_of(sel), i, so(sel), e); end
         tick();
      end
      out_ready[sel] = 1'b0;
   endtask

   task automatic test_bypass(input int sel);
      logic [127:0] dexp [3];
      logic         dinv [3];
      logic         dlr [3];
      int lat;
      logic [127:0] e;
      dexp = '{V_FIX_OUT, V_FIX_IN, V_FIX_IN};
      dinv = '{1'b0, 1'b0, 1'b1};
      dlr  = '{1'b0, 1'b1, 1'b1};
      out_ready[sel] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(sel, V_FIX_IN, dinv[i], dlr[i], dexp[i]);
         wait_out(sel, lat);
         e = exp_q.pop_front();
         n_vec++; if (lat !== n_of(sel)) begin n_err++; $display("FAIL bypass_latency cpc=%0d case=%0d got %0d want %0d", cpc_of(sel), i, lat, n_of(sel)); end
         n_vec++; if (so(sel) !== e) begin n_err++; $display("FAIL bypass_data cpc=%0d case=%0d got %h want %h", cpc_of(sel), i, so(sel), e); end
         tick();
      end
      out_ready[sel] = 1'b0;
   endtask

   task automatic test_backpressure(input int sel);
      int lat;
      logic [127:0] e;
      out_ready[sel] = 1'b0;
      send(sel, V_PLAIN, 1'b0, 1'b0, V_MIX);
      wait_out(sel, lat);
      e = exp_q.pop_front();
      n_vec++; if (lat !== n_of(sel)) begin n_err++; $display("FAIL bp_latency cpc=%0d got %0d want %0d", cpc_of(sel), lat, n_of(sel)); end
      n_vec++; if (so(sel) !== e) begin n_err++; $display("FAIL bp_data cpc=%0d got %h want %h", cpc_of(sel), so(sel), e); end
      for (int i = 0; i < 5; i++) begin
         in_valid[sel] = 1'b1;
         state_in = {$urandom, $urandom, $urandom, $urandom};
         inv = i[0];
         tick();
         n_vec++; if (ov(sel) !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cpc=%0d cyc=%0d got %b want 1", cpc_of(sel), i, ov(sel)); end
         n_vec++; if (ir(sel) !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready cpc=%0d cyc=%0d got %b want 0", cpc_of(sel), i, ir(sel)); end
         n_vec++; if (so(sel) !== V_MIX) begin n_err++; $display("FAIL bp_hold_data cpc=%0d cyc=%0d got %h want %h", cpc_of(sel), i, so(sel), V_MIX); end
      end
      in_valid[sel] = 1'b0;
      out_ready[sel] = 1'b1;
      tick();
      n_vec++; if (ov(sel) !== 1'b0) begin n_err++; $display("FAIL bp_release_valid cpc=%0d got %b want 0", cpc_of(sel), ov(sel)); end
      n_vec++; if (ir(sel) !== 1'b1) begin n_err++; $display("FAIL bp_release_ready cpc=%0d got %b want 1", cpc_of(sel), ir(sel)); end
      send(sel, V_COL_A, 1'b0, 1'b0, V_COL_B);
      wait_out(sel, lat);
      e = exp_q.pop_front();
      n_vec++; if (lat !== n_of(sel)) begin n_err++; $display("FAIL bp_next_latency cpc=%0d got %0d want %0d", cpc_of(sel), lat, n_of(sel)); end
      n_vec++; if (so(sel) !== e) begin n_err++; $display("FAIL bp_next_data cpc=%0d got %h want %h", cpc_of(sel), so(sel), e); end
      tick();
      out_ready[sel] = 1'b0;
   endtask

   task automatic test_reset_busy(input int sel);
      int lat;
      logic [127:0] e;
      out_ready[sel] = 1'b1;
      send(sel, V_FIX_IN, 1'b0, 1'b0, V_FIX_OUT);
      void'(exp_q.pop_back());
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_vec++; if (ov(sel) !== 1'b0) begin n_err++; $display("FAIL rstbusy_valid cpc=%0d got %b want 0", cpc_of(sel), ov(sel)); end
      n_vec++; if (so(sel) !== 128'h0) begin n_err++; $display("FAIL rstbusy_data cpc=%0d got %h want 0", cpc_of(sel), so(sel)); end
      n_vec++; if (ir(sel) !== 1'b1) begin n_err++; $display("FAIL rstbusy_ready cpc=%0d got %b want 1", cpc_of(sel), ir(sel)); end
      send(sel, V_PLAIN, 1'b0, 1'b0, V_MIX);
      wait_out(sel, lat);
      e = exp_q.pop_front();
      n_vec++; if (lat !== n_of(sel)) begin n_err++; $display("FAIL rstbusy_latency cpc=%0d got %0d want %0d", cpc_of(sel), lat, n_of(sel)); end
      n_vec++; if (so(sel) !== e) begin n_err++; $display("FAIL rstbusy_after cpc=%0d got %h want %h", cpc_of(sel), so(sel), e); end
      tick();
      out_ready[sel] = 1'b0;
   endtask

   initial begin
      test_reset();
      for (int s = 0; s < 3; s++) begin
         test_fips(s);
         test_inverse(s);
         test_bypass(s);
         test_backpressure(s);
      end
      test_reset_busy(0);
      test_reset_busy(1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
